// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: gathers framed serial bits into a WIDTH-bit word
// and presents it on a valid/ready port, flagging mid-frame restarts and overruns.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             complete;

  // Shift-then-patch form stays legal for WIDTH=1, where it reduces to sh = in_bit.
  function automatic logic [WIDTH-1:0] insert_bit(input logic [WIDTH-1:0] s,
                                                  input logic b);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r    = s << 1;
      r[0] = b;
    end else begin
      r          = s >> 1;
      r[WIDTH-1] = b;
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;

    if (in_valid) begin
      if (in_start) begin
        sh_d        = insert_bit(sh_q, in_bit);
        frame_err_d = (state_q == SHIFT);
        if (WIDTH == 1) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end else if (state_q == SHIFT) begin
        sh_d = insert_bit(sh_q, in_bit);
        if (cnt_q + 1'b1 == LAST) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // A finished word only lands if the output slot is empty or being drained now.
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = sh_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
